bin_to_bcd_seq: RTL and testbench

//  Sequential double-dabble binary-to-BCD converter with start/done handshake.

---
 rtl/bin_to_bcd_seq_pkg.sv | 32 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 159 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, digit-adjust constants and small helper functions.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Double-dabble correction: a digit at or above 5 would exceed 9 once
    // doubled, so 3 is added before the shift to force the decimal carry.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Width of the iteration counter that counts W-1 down to 0 (at least 1 bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Add-3-if->=5 on one BCD digit, result kept to 4 bits.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= BCD_ADJ_THRESH) begin
            res = digit + BCD_ADJ_ADD;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit cell: adds 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Correct one digit ahead of the left shift.
    always_comb begin
        digit_o = bcd_adjust(digit_i);
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/done handshake.
// One conversion takes W shift cycles plus one result cycle; bcd/ovf only
// change on the done_tick edge, so they never show partial values.
// Optional feature: define BCD_BLANK_EN to add the blank[DIGITS-1:0] output
// (leading-zero blanking flags registered with the result).
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int NW = cnt_width(W);
    localparam logic [NW-1:0] N_INIT = NW'(W - 1);

    state_e          state_q,     state_d;
    logic [NW-1:0]   n_q,         n_d;
    logic [W-1:0]    bin_shift_q, bin_shift_d;
    logic [BW-1:0]   work_q,      work_d;
    logic            acc_q,       acc_d;
    logic [BW-1:0]   bcd_q,       bcd_d;
    logic            ovf_q,       ovf_d;
    logic            done_q,      done_d;
    logic            ready_q,     ready_d;
    logic [BW-1:0]   adj_s;

    // One adjust cell per digit of the working register.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[4*gi +: 4]),
            .digit_o (adj_s[4*gi +: 4])
        );
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_s;

    // Digit i is blanked when it and every higher digit are zero; the ones
    // digit is never blanked so a zero value still shows "0".
    always_comb begin
        logic hi_zero;
        hi_zero    = 1'b1;
        blank_s    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero & (work_q[4*i +: 4] == 4'd0);
            blank_s[i] = hi_zero;
        end
        blank_s[0] = 1'b0;
    end
`endif

    // Next-state and datapath: capture on start, adjust-and-shift in OP,
    // publish the result in DONE.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        bin_shift_d = bin_shift_q;
        work_d      = work_q;
        acc_d       = acc_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
`ifdef BCD_BLANK_EN
        blank_d     = blank_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_OP;
                    bin_shift_d = bin;
                    work_d      = '0;
                    n_d         = N_INIT;
                    acc_d       = 1'b0;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_OP: begin
                // The bit leaving the top digit is a lost 10^DIGITS multiple.
                {work_d, bin_shift_d} = {adj_s[BW-2:0], bin_shift_q, 1'b0};
                acc_d = acc_q | adj_s[BW-1];
                if (n_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    n_d = n_q - 1'b1;
                end
            end
            ST_DONE: begin
                bcd_d   = work_q;
                ovf_d   = acc_q;
                done_d  = 1'b1;
`ifdef BCD_BLANK_EN
                blank_d = blank_s;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State, working and output registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            bin_shift_q <= '0;
            work_q      <= '0;
            acc_q       <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
`ifdef BCD_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            bin_shift_q <= bin_shift_d;
            work_q      <= work_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
`ifdef BCD_BLANK_EN
            blank_q     <= blank_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign done_tick = done_q;
    assign bcd       = bcd_q;
    assign ovf       = ovf_q;
`ifdef BCD_BLANK_EN
    assign blank     = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Two instances (3 digits and
// 2 digits) share clock, reset and stimulus so every conversion checks both
// the normal and the truncating/overflow case. Define BCD_BLANK_EN to also
// check the blank output.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  bin;
    logic        rdy3, dn3, ovf3;
    logic [11:0] bcd3;
    logic        rdy2, dn2, ovf2;
    logic [7:0]  bcd2;
`ifdef BCD_BLANK_EN
    logic [2:0]  blk3;
    logic [1:0]  blk2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.W(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(rdy3), .done_tick(dn3), .bcd(bcd3), .ovf(ovf3)
`ifdef BCD_BLANK_EN
        , .blank(blk3)
`endif
    );

    bin_to_bcd_seq #(.W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .ready(rdy2), .done_tick(dn2), .bcd(bcd2), .ovf(ovf2)
`ifdef BCD_BLANK_EN
        , .blank(blk2)
`endif
    );

    // ---------------- reference model (plain decimal arithmetic) ----------
    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] ref_bcd(input int v, input int d);
        int m;
        logic [15:0] r;
        m = v % pow10(d);
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int d);
        return v >= pow10(d);
    endfunction

    function automatic logic [3:0] ref_blank(input int v, input int d);
        int m;
        logic [3:0] r;
        m = v % pow10(d);
        r = '0;
        for (int i = 1; i < d; i++) r[i] = ((m / pow10(i)) == 0);
        return r;
    endfunction

    // ---------------- checker ---------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion of v with garbage on start/bin while busy.
    task automatic run_conv(input logic [7:0] v);
        int  waited;
        int  lat;
        bit  seen;
        waited = 0;
        while (!(rdy3 && rdy2) && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_start", {30'd0, rdy3, rdy2}, 32'd3);
        start = 1'b1;
        bin   = v;
        @(posedge clk); #1;
        check("ready_low_in_op", {30'd0, rdy3, rdy2}, 32'd0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            start = 1'($urandom_range(0, 1));
            bin   = 8'($urandom);
            @(posedge clk); #1;
            lat++;
            if (dn3) seen = 1'b1;
        end
        start = 1'b0;
        check("latency", lat, 32'd9);
        check("done2_with_done3", {31'd0, dn2}, 32'd1);
        check("ready_at_done", {30'd0, rdy3, rdy2}, 32'd3);
        check("bcd3", {20'd0, bcd3}, {16'd0, ref_bcd(v, 3)});
        check("ovf3", {31'd0, ovf3}, {31'd0, ref_ovf(v, 3)});
        check("bcd2", {24'd0, bcd2}, {16'd0, ref_bcd(v, 2)});
        check("ovf2", {31'd0, ovf2}, {31'd0, ref_ovf(v, 2)});
`ifdef BCD_BLANK_EN
        check("blank3", {29'd0, blk3}, {28'd0, ref_blank(v, 3)});
        check("blank2", {30'd0, blk2}, {28'd0, ref_blank(v, 2)});
`endif
        @(posedge clk); #1;
        check("done_one_cycle", {30'd0, dn3, dn2}, 32'd0);
        check("bcd3_held", {20'd0, bcd3}, {16'd0, ref_bcd(v, 3)});
    endtask

    logic [7:0] hist [60];

    initial begin
        bool_init: begin end
        // Reset held with start asserted.
        reset = 1'b0;
        start = 1'b1;
        bin   = 8'd255;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {30'd0, rdy3, rdy2}, 32'd3);
        check("rst_done", {30'd0, dn3, dn2}, 32'd0);
        check("rst_bcd3", {20'd0, bcd3}, 32'd0);
        check("rst_bcd2", {24'd0, bcd2}, 32'd0);
        check("rst_ovf", {30'd0, ovf3, ovf2}, 32'd0);
`ifdef BCD_BLANK_EN
        check("rst_blank", {27'd0, blk3, blk2}, 32'd0);
`endif
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed corner values.
        run_conv(8'd255);
        run_conv(8'd200);
        run_conv(8'd99);
        run_conv(8'd7);
        run_conv(8'd0);
        run_conv(8'd105);

        // start held high with bin changing every cycle.
        for (int c = 0; c < 60; c++) begin
            start   = 1'b1;
            bin     = 8'($urandom);
            hist[c] = bin;
            @(posedge clk); #1;
            check("stream_done", {31'd0, dn3}, {31'd0, ((c % 10) == 9)});
            if ((c % 10) == 9) begin
                check("stream_bcd3", {20'd0, bcd3}, {16'd0, ref_bcd(hist[c-9], 3)});
                check("stream_bcd2", {24'd0, bcd2}, {16'd0, ref_bcd(hist[c-9], 2)});
                check("stream_ovf2", {31'd0, ovf2}, {31'd0, ref_ovf(hist[c-9], 2)});
            end
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Reset during OP cycle 4 of a conversion aborts it.
        start = 1'b1;
        bin   = 8'd137;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_bcd3", {20'd0, bcd3}, 32'd0);
        check("abort_ready", {30'd0, rdy3, rdy2}, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        begin
            bit got_done;
            got_done = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk); #1;
                if (dn3 || dn2) got_done = 1'b1;
            end
            check("abort_no_done", {31'd0, got_done}, 32'd0);
        end
        check("abort_bcd_stays0", {20'd0, bcd3}, 32'd0);
        run_conv(8'd42);
        check("after_abort_42", {20'd0, bcd3}, 32'h042);

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) run_conv(8'(v));

        // A few random values in random order.
        for (int i = 0; i < 20; i++) run_conv(8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
